div_circ: RTL and testbench
===========================

Name: div_circ

Overview:
- Sequential 32-bit unsigned restoring divider, shift-subtract, one quotient bit per clock.
- Companion to the shift-add multiplier datapath, performing the inverse operation.
- Contains its own control FSM and iteration counter and exposes a start/done handshake.
- Sits beside the multiplier in the arithmetic unit and is driven by the same top-level controller.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; the counter is clog2(WIDTH)+1 bits (6 at default).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a division; sampled only in IDLE or DONE
- dividend  in  WIDTH  numerator, latched on the accepted start
- divisor  in  WIDTH  denominator, latched on the accepted start
- quotient  out  WIDTH  result quotient (register)
- remainder  out  WIDTH  result remainder (register)
- counter  out  6  iterations completed in the current operation
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, high in DONE
- div_by_zero  out  1  set with done when the latched divisor is 0; held until the next accepted start

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-RUN:
  - state goes to IDLE.
  - quotient, remainder, counter, busy, done, div_by_zero all go to 0.
  - internal divisor register goes to 0.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE).
- IDLE:
  - start=1: latch divisor, load {rem,quot}={0,dividend}, counter=0, clear div_by_zero.
  - Next state is RUN if divisor!=0.
  - If divisor==0, next state is DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - Form a 33-bit partial remainder p={rem,quot[WIDTH-1]}, then shift quot left by 1.
  - If p >= {0,divisor}: rem=p-divisor and quot[0]=1. Otherwise rem=p[WIDTH-1:0] and quot[0]=0.
  - The comparison must use 33 bits, because p can exceed 2^32-1 when the divisor is at least 2^31.
  - counter increments each cycle. When counter==WIDTH-1 at the edge, the transition goes to DONE and counter becomes WIDTH.
  - start is ignored; operand inputs are ignored.
- quotient and remainder outputs are the quot/rem registers. They are intermediate during RUN and final once done is high. They hold their value in IDLE until the next accepted start.
- DONE:
  - Lasts exactly one cycle.
  - With start=1: accepted as in IDLE (back-to-back operation), and the next state is RUN or DONE (divide by zero).
  - With start=0: next state is IDLE.
- Latency: start accepted at edge E0 gives RUN for edges E1..E32, and done is high in the cycle after E32 (33 clocks after acceptance). Divide by zero gives done in the cycle after E0.
- Throughput: one division per 33 clocks with start held high.
- Result invariant: dividend == quotient*divisor + remainder, with remainder < divisor (divisor != 0).
- No X propagation: all state registers are reset; counter never exceeds WIDTH.

Test Plan:
- Basic division: dividend=100, divisor=7, start pulse.
  - Required: busy for 32 cycles, done 33 clocks after the start edge, quotient=14, remainder=2, counter=32, div_by_zero=0.
- Edge operands:
  - dividend=0xFFFFFFFF, divisor=1: quotient=0xFFFFFFFF, remainder=0.
  - dividend=0xFFFFFFFF, divisor=0x80000000: quotient=1, remainder=0x7FFFFFFF (exercises the 33-bit compare).
  - dividend=5, divisor=9: quotient=0, remainder=5.
- Divide by zero: dividend=0x1234, divisor=0.
  - Required: done one cycle after start, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, busy never high.
- Start while busy: start pulsed at RUN cycle 10 with different operands.
  - Required: ignored, and the original result completes unchanged.
- Back-to-back: start held high across DONE with new operands 1000/33.
  - Required: the second run starts immediately, giving quotient=30, remainder=10 done 33 clocks later.
- Reset mid-operation: rst at RUN cycle 16.
  - Required: IDLE, all outputs 0 next cycle. A following start with 50/5 gives quotient=10, remainder=0.
- Random: 1000 random operand pairs checked against the reference model, with the invariant asserted on every done.

Source files
------------

// File: rtl/div_circ_if.sv
// Handshake and operand/result bundle between the arithmetic-unit controller
// and the restoring divider.
interface div_circ_if #(
    parameter int WIDTH = 32
) ();
    localparam int CW = $clog2(WIDTH) + 1;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [CW-1:0]    counter;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, counter, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, counter, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_circ.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// IDLE -> RUN (WIDTH cycles) -> DONE, with a start/done handshake.
module div_circ #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_circ_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   partial;
    logic             fits;
    logic [WIDTH-1:0] diff;

    assign accept    = bus.start && (state_q != RUN);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // The partial remainder needs WIDTH+1 bits: with a divisor >= 2^(WIDTH-1)
    // it can exceed 2^WIDTH-1, and the truncated difference is still exact.
    assign partial = {rem_q, quot_q[WIDTH-1]};
    assign fits    = (partial >= {1'b0, dvsr_q});
    assign diff    = partial[WIDTH-1:0] - dvsr_q;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) state_d = (bus.divisor == '0) ? DONE : RUN;
                else           state_d = IDLE;
            end
            RUN:     if (last_iter) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal gets a hold default first so no path infers a latch.
    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        dbz_d  = dbz_q;
        if (accept) begin
            dvsr_d = bus.divisor;
            cnt_d  = '0;
            if (bus.divisor == '0) begin
                quot_d = '1;
                rem_d  = bus.dividend;
                dbz_d  = 1'b1;
            end else begin
                quot_d = bus.dividend;
                rem_d  = '0;
                dbz_d  = 1'b0;
            end
        end else if (state_q == RUN) begin
            quot_d = {quot_q[WIDTH-2:0], fits};
            rem_d  = fits ? diff : partial[WIDTH-1:0];
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_comb begin
        bus.busy        = (state_q == RUN);
        bus.done        = (state_q == DONE);
        bus.quotient    = quot_q;
        bus.remainder   = rem_q;
        bus.counter     = cnt_q;
        bus.div_by_zero = dbz_q;
    end
endmodule

// File: tb/tb_div_circ.sv
// Directed and random checks of div_circ against a scoreboard of expected
// results pushed at each accepted start and compared on done.
module tb_div_circ;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_circ_if #(.WIDTH(W)) bus ();
    div_circ #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t sb[$];
    int   passed   = 0;
    int   total    = 0;
    int   cyc      = 0;
    int   e0       = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.busy) busy_cnt++;
    endtask

    // Called at a negedge; the start is accepted on the following rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.a   = a;
        e.b   = b;
        e.dbz = (b == '0);
        e.q   = (b == '0) ? '1 : a / b;
        e.r   = (b == '0) ? a  : a % b;
        sb.push_back(e);
        e0       = cyc + 1;
        busy_cnt = 0;
    endtask

    task automatic wait_done();
        exp_t e;
        int   n = 0;
        do begin
            tick();
            bus.start = 1'b0;
            n++;
        end while (!bus.done && n < 100);
        if (!bus.done) begin
            check("done_timeout", 64'(bus.done), 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check("quotient",    64'(bus.quotient),    64'(e.q));
        check("remainder",   64'(bus.remainder),   64'(e.r));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
        check("counter",     64'(bus.counter),     e.dbz ? 64'd0 : 64'd32);
        check("latency",     64'(cyc - e0 + 1),    e.dbz ? 64'd1 : 64'd33);
        check("busy_cycles", 64'(busy_cnt),        e.dbz ? 64'd0 : 64'd32);
        if (!e.dbz) begin
            check("invariant",  64'(bus.quotient) * 64'(e.b) + 64'(bus.remainder), 64'(e.a));
            check("rem_lt_div", 64'(bus.remainder < e.b), 64'd1);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_quotient"},  64'(bus.quotient),    64'd0);
        check({tag, "_remainder"}, 64'(bus.remainder),   64'd0);
        check({tag, "_counter"},   64'(bus.counter),     64'd0);
        check({tag, "_busy"},      64'(bus.busy),        64'd0);
        check({tag, "_done"},      64'(bus.done),        64'd0);
        check({tag, "_dbz"},       64'(bus.div_by_zero), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ea[3];
        logic [W-1:0] eb[3];
        logic [W-1:0] ra, rb;
        ea = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        eb = '{32'd1,         32'h8000_0000, 32'd9};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_done", 64'(bus.done), 64'd0);

        // Basic division, then results must hold in IDLE.
        issue(32'd100, 32'd7);
        wait_done();
        tick();
        check("hold_quotient",  64'(bus.quotient),  64'd14);
        check("hold_remainder", 64'(bus.remainder), 64'd2);
        check("hold_done",      64'(bus.done),      64'd0);
        check("hold_busy",      64'(bus.busy),      64'd0);

        for (int i = 0; i < 3; i++) begin
            issue(ea[i], eb[i]);
            wait_done();
            tick();
        end

        issue(32'h1234, 32'd0);
        wait_done();
        tick();

        // A start pulse during RUN must be ignored.
        issue(32'd1_000_000, 32'd123);
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd0;
        wait_done();
        tick();

        // Back-to-back: start held through DONE.
        issue(32'd123_456, 32'd789);
        wait_done();
        issue(32'd1000, 32'd33);
        wait_done();
        tick();

        // Reset in the middle of RUN.
        issue(32'hDEAD_BEEF, 32'd3);
        tick();
        bus.start = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        check_cleared("midrun_reset");
        rst = 1'b0;
        sb.delete();
        tick();
        issue(32'd50, 32'd5);
        wait_done();
        tick();

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 97 == 0) rb = '0;
            issue(ra, rb);
            wait_done();
        end
        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
